// File: rtl/a2d_spi_serf.sv
// rtl/a2d_spi_serf.sv - SPI responder modelling the far-end A2D converter
module a2d_spi_serf #(
    parameter logic [2:0] RST_CHNL   = 3'b000,
    parameter int         FRAME_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] ana_data,
    output logic [2:0]  chnl,
    output logic        cmd_vld,
    output logic        err
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    state_t      state, nxt_state;
    logic        ss_ff1, ss_ff2, ss_ff3;
    logic        sclk_ff1, sclk_ff2, sclk_ff3;
    logic        mosi_ff1, mosi_ff2, mosi_ff3;
    logic [15:0] tx_sr;
    logic [13:0] rx_sr;
    logic [4:0]  bit_cnt;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;

    // Only rx bits [13:11] are ever used, so the upper two bits are not kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {ss_ff3, ss_ff2, ss_ff1}       <= 3'b111;
            {sclk_ff3, sclk_ff2, sclk_ff1} <= 3'b111;
            {mosi_ff3, mosi_ff2, mosi_ff1} <= 3'b000;
        end else begin
            {ss_ff3, ss_ff2, ss_ff1}       <= {ss_ff2, ss_ff1, SS_n};
            {sclk_ff3, sclk_ff2, sclk_ff1} <= {sclk_ff2, sclk_ff1, SCLK};
            {mosi_ff3, mosi_ff2, mosi_ff1} <= {mosi_ff2, mosi_ff1, MOSI};
        end
    end

    assign ss_fall   =  ss_ff3   & ~ss_ff2;
    assign ss_rise   = ~ss_ff3   &  ss_ff2;
    assign sclk_rise = ~sclk_ff3 &  sclk_ff2;
    assign sclk_fall =  sclk_ff3 & ~sclk_ff2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (ss_fall) nxt_state = SHIFT;
            SHIFT:   if (ss_rise) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            chnl    <= RST_CHNL;
            cmd_vld <= 1'b0;
            err     <= 1'b0;
        end else begin
            cmd_vld <= 1'b0;
            err     <= 1'b0;
            if (state == IDLE) begin
                if (ss_fall) begin
                    tx_sr   <= {4'h0, ana_data};
                    rx_sr   <= '0;
                    bit_cnt <= '0;
                end
            end else if (ss_rise) begin
                // Frame end takes priority; a coincident SCLK edge is dropped
                if (bit_cnt == FRAME_CNT) begin
                    chnl    <= rx_sr[13:11];
                    cmd_vld <= 1'b1;
                end else begin
                    err     <= 1'b1;
                end
            end else begin
                if (sclk_rise) begin
                    rx_sr <= {rx_sr[12:0], mosi_ff3};
                    if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
                end
                if (sclk_fall && bit_cnt != 5'd0) tx_sr <= {tx_sr[14:0], 1'b0};
            end
        end
    end

    assign MISO = (state == SHIFT) & tx_sr[15];

endmodule
